// File: rtl/sdr_general_receive.sv
// UDP payload receiver: decodes discovery / erase / program packets for a
// remote flash programmer, streams program bytes and tracks sequence numbers.
module sdr_general_receive #(
    parameter logic [15:0] PORT  = 16'd1024,
    parameter int unsigned BLOCK = 256
) (
    input  logic        rx_clock,
    input  logic        reset,
    input  logic        udp_rx_active,
    input  logic [7:0]  udp_rx_data,
    input  logic [15:0] to_port,
    input  logic        discovery_ACK,
    input  logic        erase_ACK,
    input  logic        send_more_ACK,
    output logic        discovery,
    output logic        erase,
    output logic        send_more,
    output logic [7:0]  prog_wrdata,
    output logic        prog_wrreq,
    output logic [31:0] sequence_number,
    output logic [15:0] checksum,
    output logic        seq_error
);

    localparam int unsigned CNT_W = ($clog2(BLOCK) > 2) ? $clog2(BLOCK) : 2;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BLOCK - 1);
    localparam logic [CNT_W-1:0] LAST_HDR  = CNT_W'(3);

    typedef enum logic [2:0] {
        IDLE, SEQ, CMD, SKIP, PLEN, PDATA, DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE, CMD_DISC, CMD_ERASE, CMD_PROG
    } cmd_t;

    state_t           state_q;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      seq_q;
    logic             active_q;
    logic             exp_valid_q;
    logic             disc_q;
    logic             erase_q;
    logic             send_more_q;
    logic [7:0]       wrdata_q;
    logic             wrreq_q;
    logic [31:0]      seq_num_q;
    logic [15:0]      checksum_q;
    logic             seq_err_q;

    // Packet parser, request flags and program-stream bookkeeping
    always_ff @(posedge rx_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_NONE;
            cnt_q       <= '0;
            seq_q       <= '0;
            // Treat a packet already in flight as seen so its tail is ignored
            active_q    <= udp_rx_active;
            exp_valid_q <= 1'b0;
            disc_q      <= 1'b0;
            erase_q     <= 1'b0;
            send_more_q <= 1'b0;
            wrdata_q    <= '0;
            wrreq_q     <= 1'b0;
            seq_num_q   <= '0;
            checksum_q  <= '0;
            seq_err_q   <= 1'b0;
        end else begin
            active_q  <= udp_rx_active;
            wrreq_q   <= 1'b0;
            seq_err_q <= 1'b0;

            if (discovery_ACK) disc_q      <= 1'b0;
            if (erase_ACK)     erase_q     <= 1'b0;
            if (send_more_ACK) send_more_q <= 1'b0;

            if (state_q != IDLE && !udp_rx_active) begin
                // End of packet: later assignments let a set beat a same-cycle ACK
                state_q <= IDLE;
                case (cmd_q)
                    CMD_DISC: disc_q <= 1'b1;
                    CMD_ERASE: begin
                        erase_q     <= 1'b1;
                        checksum_q  <= '0;
                        exp_valid_q <= 1'b0;
                    end
                    default: ;
                endcase
                if (state_q == DONE) begin
                    seq_num_q   <= seq_q;
                    send_more_q <= 1'b1;
                    exp_valid_q <= 1'b1;
                    if (exp_valid_q && (seq_q != seq_num_q + 32'd1)) seq_err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (udp_rx_active && !active_q && (to_port == PORT)) begin
                            seq_q   <= {24'h000000, udp_rx_data};
                            cnt_q   <= CNT_W'(1);
                            cmd_q   <= CMD_NONE;
                            state_q <= SEQ;
                        end
                    end
                    SEQ: begin
                        seq_q <= {seq_q[23:0], udp_rx_data};
                        if (cnt_q == LAST_HDR) begin
                            cnt_q   <= '0;
                            state_q <= CMD;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    CMD: begin
                        case (udp_rx_data)
                            8'h02: begin cmd_q <= CMD_DISC;  state_q <= SKIP; end
                            8'h04: begin cmd_q <= CMD_ERASE; state_q <= SKIP; end
                            8'h05: begin cmd_q <= CMD_PROG;  state_q <= PLEN; end
                            default: state_q <= SKIP;
                        endcase
                    end
                    PLEN: begin
                        if (cnt_q == LAST_HDR) begin
                            cnt_q   <= '0;
                            state_q <= PDATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PDATA: begin
                        wrreq_q    <= 1'b1;
                        wrdata_q   <= udp_rx_data;
                        checksum_q <= checksum_q + 16'(udp_rx_data);
                        if (cnt_q == LAST_DATA) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign discovery       = disc_q;
    assign erase           = erase_q;
    assign send_more       = send_more_q;
    assign prog_wrdata     = wrdata_q;
    assign prog_wrreq      = wrreq_q;
    assign sequence_number = seq_num_q;
    assign checksum        = checksum_q;
    assign seq_error       = seq_err_q;

endmodule

// File: tb/tb_sdr_general_receive.sv
// Directed bench for sdr_general_receive: discovery, erase, program streams,
// sequence checking, flag handshakes and mid-packet reset.
module tb_sdr_general_receive;

    logic        clk = 1'b0;
    logic        reset;
    logic        udp_rx_active;
    logic [7:0]  udp_rx_data;
    logic [15:0] to_port;
    logic        discovery_ACK, erase_ACK, send_more_ACK;
    logic        discovery, erase, send_more;
    logic [7:0]  prog_wrdata;
    logic        prog_wrreq;
    logic [31:0] sequence_number;
    logic [15:0] checksum;
    logic        seq_error;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int err_cyc  = 0;
    logic [7:0] last_wr = '0;
    int base;

    always #5 clk = ~clk;

    sdr_general_receive dut (
        .rx_clock        (clk),
        .reset           (reset),
        .udp_rx_active   (udp_rx_active),
        .udp_rx_data     (udp_rx_data),
        .to_port         (to_port),
        .discovery_ACK   (discovery_ACK),
        .erase_ACK       (erase_ACK),
        .send_more_ACK   (send_more_ACK),
        .discovery       (discovery),
        .erase           (erase),
        .send_more       (send_more),
        .prog_wrdata     (prog_wrdata),
        .prog_wrreq      (prog_wrreq),
        .sequence_number (sequence_number),
        .checksum        (checksum),
        .seq_error       (seq_error)
    );

    // Count write strobes and seq_error high cycles as seen at each edge
    always @(posedge clk) begin
        if (prog_wrreq) begin
            strobes++;
            last_wr = prog_wrdata;
        end
        if (seq_error) err_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        udp_rx_active = 1'b1;
        udp_rx_data   = b;
    endtask

    // Send one packet; program packets carry 4 length bytes then ndata bytes.
    // rst_at > 0 pulses reset on that data byte; ack_end raises send_more_ACK
    // in the same cycle the packet ends.
    task automatic send_pkt(input logic [15:0] port, input logic [31:0] seq,
                            input logic [7:0] cmd, input int ndata,
                            input logic [7:0] dval, input int rst_at,
                            input bit ack_end);
        to_port = port;
        for (int i = 3; i >= 0; i--) put_byte(seq[i*8 +: 8]);
        put_byte(cmd);
        if (cmd == 8'h05) for (int i = 0; i < 4; i++) put_byte(8'h00);
        for (int i = 1; i <= ndata; i++) begin
            put_byte(dval);
            reset = (i == rst_at);
        end
        @(negedge clk);
        reset         = 1'b0;
        udp_rx_active = 1'b0;
        udp_rx_data   = 8'h00;
        if (ack_end) send_more_ACK = 1'b1;
        @(negedge clk);
        send_more_ACK = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack_all();
        discovery_ACK = 1'b1;
        erase_ACK     = 1'b1;
        send_more_ACK = 1'b1;
        @(negedge clk);
        discovery_ACK = 1'b0;
        erase_ACK     = 1'b0;
        send_more_ACK = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        udp_rx_active = 1'b0;
        udp_rx_data   = 8'h00;
        to_port       = 16'd1024;
        discovery_ACK = 1'b0;
        erase_ACK     = 1'b0;
        send_more_ACK = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_discovery", 32'(discovery), 32'd0);
        check("rst_erase", 32'(erase), 32'd0);
        check("rst_send_more", 32'(send_more), 32'd0);
        check("rst_wrreq", 32'(prog_wrreq), 32'd0);
        check("rst_seqnum", sequence_number, 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_seq_error", 32'(seq_error), 32'd0);

        // Discovery on the accepted port, then ACK handshake
        send_pkt(16'd1024, 32'd0, 8'h02, 0, 8'h00, 0, 1'b0);
        check("disc_set", 32'(discovery), 32'd1);
        check("disc_no_erase", 32'(erase), 32'd0);
        check("disc_no_strobe", 32'(strobes), 32'd0);
        discovery_ACK = 1'b1;
        @(negedge clk);
        discovery_ACK = 1'b0;
        check("disc_ack_clear", 32'(discovery), 32'd0);

        // Wrong port is ignored
        send_pkt(16'd1025, 32'd0, 8'h02, 0, 8'h00, 0, 1'b0);
        check("port_miss_disc", 32'(discovery), 32'd0);
        check("port_miss_strobe", 32'(strobes), 32'd0);

        // Full program packet, seq 5, 256 x 0x01
        send_pkt(16'd1024, 32'd5, 8'h05, 256, 8'h01, 0, 1'b0);
        check("prog5_strobes", 32'(strobes), 32'd256);
        check("prog5_checksum", 32'(checksum), 32'h0100);
        check("prog5_seqnum", sequence_number, 32'd5);
        check("prog5_send_more", 32'(send_more), 32'd1);
        check("prog5_no_err", 32'(err_cyc), 32'd0);
        check("prog5_wrdata", 32'(last_wr), 32'h01);
        ack_all();
        check("prog5_ack", 32'(send_more), 32'd0);

        // Sequence gap 5 -> 7, extra trailing bytes ignored
        send_pkt(16'd1024, 32'd7, 8'h05, 260, 8'h02, 0, 1'b0);
        check("prog7_strobes", 32'(strobes), 32'd512);
        check("prog7_err_pulse", 32'(err_cyc), 32'd1);
        check("prog7_seqnum", sequence_number, 32'd7);
        check("prog7_checksum", 32'(checksum), 32'h0300);
        ack_all();

        // Erase clears checksum and expected-sequence tracking
        send_pkt(16'd1024, 32'd9, 8'h04, 3, 8'hAA, 0, 1'b0);
        check("erase_set", 32'(erase), 32'd1);
        check("erase_checksum", 32'(checksum), 32'd0);
        check("erase_no_strobe", 32'(strobes), 32'd512);
        ack_all();
        check("erase_ack", 32'(erase), 32'd0);

        // First packet after erase, then 32-bit wrap, with merge and set-vs-ACK
        send_pkt(16'd1024, 32'hFFFF_FFFF, 8'h05, 256, 8'hFF, 0, 1'b0);
        check("wrapA_no_err", 32'(err_cyc), 32'd1);
        check("wrapA_seqnum", sequence_number, 32'hFFFF_FFFF);
        check("wrapA_checksum", 32'(checksum), 32'hFF00);
        send_pkt(16'd1024, 32'd0, 8'h05, 256, 8'hFF, 0, 1'b1);
        check("wrapB_no_err", 32'(err_cyc), 32'd1);
        check("wrapB_seqnum", sequence_number, 32'd0);
        check("wrapB_checksum", 32'(checksum), 32'hFE00);
        check("set_beats_ack", 32'(send_more), 32'd1);
        ack_all();
        check("wrapB_ack", 32'(send_more), 32'd0);

        // Short program packet: strobes happen, no completion
        send_pkt(16'd1024, 32'd1, 8'h05, 100, 8'h03, 0, 1'b0);
        check("short_strobes", 32'(strobes), 32'd1124);
        check("short_send_more", 32'(send_more), 32'd0);
        check("short_seqnum", sequence_number, 32'd0);
        check("short_checksum", 32'(checksum), 32'hFF2C);

        // Unknown command is ignored
        send_pkt(16'd1024, 32'd2, 8'h09, 20, 8'h05, 0, 1'b0);
        check("unk_flags", {29'd0, discovery, erase, send_more}, 32'd0);
        check("unk_strobes", 32'(strobes), 32'd1124);

        // Erase, then program aborted by reset at data byte 50
        send_pkt(16'd1024, 32'd3, 8'h04, 0, 8'h00, 0, 1'b0);
        check("erase2_set", 32'(erase), 32'd1);
        base = strobes;
        send_pkt(16'd1024, 32'd3, 8'h05, 300, 8'h07, 50, 1'b0);
        check("rst_mid_strobes", 32'(strobes - base), 32'd49);
        check("rst_mid_checksum", 32'(checksum), 32'd0);
        check("rst_mid_flags", {29'd0, discovery, erase, send_more}, 32'd0);
        check("rst_mid_seqnum", sequence_number, 32'd0);

        // Receiver recovers for the next packet
        send_pkt(16'd1024, 32'd0, 8'h02, 0, 8'h00, 0, 1'b0);
        check("recover_disc", 32'(discovery), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdr_general_receive.md
SDR_GENERAL_RECEIVE -- requirements
Module: sdr_general_receive

Interface
REQ-001 SHALL have parameter PORT, default 16'd1024, UDP destination port accepted.
REQ-002 SHALL have parameter BLOCK, default 256, program data bytes per packet.
REQ-003 SHALL use one clock, rx_clock; reset is synchronous and active-high, named reset.
REQ-004 rx_clock  in  1  byte clock for all logic.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 udp_rx_active  in  1  high while payload bytes stream, one byte per clock.
REQ-007 udp_rx_data  in  8  payload byte, valid when udp_rx_active high.
REQ-008 to_port  in  16  destination port of the current packet, stable while udp_rx_active high.
REQ-009 discovery_ACK / erase_ACK / send_more_ACK  in  1 each  transmitter acknowledges.
REQ-010 discovery / erase / send_more  out  1 each  held request flags.
REQ-011 prog_wrdata  out  8  program byte; prog_wrreq  out  1  one-cycle write strobe.
REQ-012 sequence_number  out  32  sequence number of the last complete program packet.
REQ-013 checksum  out  16  running sum of program bytes since last erase.
REQ-014 seq_error  out  1  one-cycle pulse on program sequence discontinuity.

Function
REQ-015 Payload format: bytes 0-3 sequence number (big-endian), byte 4 command, then command body.
REQ-016 Commands: 8'h02 discovery, 8'h04 erase, 8'h05 program; others are ignored to end of packet.
REQ-017 Program body: bytes 5-8 block count (ignored), bytes 9..8+BLOCK data.
REQ-018 Packets with to_port != PORT (sampled on first byte) SHALL be ignored entirely.
REQ-019 FSM states: IDLE, SEQ, CMD, SKIP, PLEN, PDATA, DONE.
REQ-020 IDLE->SEQ on rising udp_rx_active with matching port, first byte captured same cycle.
REQ-021 SEQ captures bytes 0-3; CMD decodes byte 4; PLEN counts bytes 5-8; PDATA counts data bytes.
REQ-022 Any state other than IDLE SHALL return to IDLE when udp_rx_active is low.
REQ-023 Discovery/erase SHALL be set in the cycle after udp_rx_active falls, only if byte 4 was received.
REQ-024 PDATA: prog_wrreq high one cycle, registered, per data byte; prog_wrdata = that byte, latency 1 clock.
REQ-025 After the BLOCK-th data byte, extra bytes SHALL be ignored (SKIP) and no further strobes issued.
REQ-026 At end of a program packet with all BLOCK bytes: sequence_number <= packet seq, send_more <= 1.
REQ-027 Program packet ending before BLOCK data bytes: no send_more, sequence_number unchanged; bytes already strobed remain written.
REQ-028 checksum SHALL add each strobed byte, 16-bit modulo wrap, zero-extended.
REQ-029 Each flag SHALL clear the cycle after its ACK is high; a set event in the same cycle as ACK SHALL win.
REQ-030 A new request while a flag is already high SHALL merge (flag stays high).
REQ-031 Erase completion SHALL clear checksum and the expected-sequence valid bit.
REQ-032 seq_error SHALL pulse when a complete program packet seq != previous+1 while expected-sequence valid; packet still accepted.
REQ-033 First complete program packet after reset or erase SHALL set expected-sequence valid without seq_error.
REQ-034 sequence arithmetic is 32-bit, 32'hFFFFFFFF+1 wraps to 0 with no error.

Reset
REQ-035 reset SHALL force IDLE, all flags 0, prog_wrreq 0, seq_error 0, sequence_number 0, checksum 0, expected-valid 0.
REQ-036 reset during a packet SHALL abort it; remaining bytes of that packet SHALL be ignored until udp_rx_active falls.

Verification
REQ-037 Discovery to port 1024, seq 0, cmd 02 -> discovery=1 one clock after active falls; ACK pulse -> discovery=0 next clock.
REQ-038 Discovery to port 1025 -> no flag, no strobe.
REQ-039 Program seq 5, 256 bytes 0x01 -> 256 prog_wrreq, checksum=0x0100, sequence_number=5, send_more=1.
REQ-040 Program seq 5 then seq 7 -> seq_error single pulse, sequence_number=7; seq FFFFFFFF then 0 -> no error.
REQ-041 Program packet with 100 data bytes -> 100 strobes, send_more stays 0.
REQ-042 Erase then program with 300 data bytes, reset asserted at data byte 50 -> checksum=0, 49 strobes max, flags 0.
